id_ex_stage_reg: RTL and testbench

//  ID/EX pipeline register of the pipelined RV32I core, directly downstream of the control unit.
//  - Captures the decode-stage control bundle plus operands.
//  - Detects load-use hazards: holds PC and IF/ID, and inserts a bubble into EX.
//  - Applies branch/jump flushes.
//  - Latches a sticky halt when a decoded instruction deasserts pc_write (EBREAK).

---
 rtl/id_ex_stage_reg_pkg.sv | 41 ++++
 rtl/hazard_detect.sv | 22 ++
 rtl/id_ex_stage_reg.sv | 156 +++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared encodings for the ID/EX stage: control-bundle layout, ALU-op and opcode constants,
// and the stage FSM states.
package id_ex_stage_reg_pkg;

   localparam int CTRL_W = 9;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;  // loads/stores: address add
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // compare for branches
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // funct3/funct7 decides
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;  // funct3 decides, imm operand

   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic       branch;
      logic       mem_read;
      logic       mem_to_reg;
      logic [1:0] alu_op;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic       pc_write;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = ctrl_t'({CTRL_W{1'b0}});

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: the load in EX writes a register that the instruction in ID reads.
module hazard_detect #(
   parameter int REG_AW = 5
) (
   input  logic              i_ex_valid,
   input  logic              i_ex_mem_read,
   input  logic [REG_AW-1:0] i_ex_rd,
   input  logic              i_id_valid,
   input  logic [REG_AW-1:0] i_id_rs1,
   input  logic [REG_AW-1:0] i_id_rs2,
   output logic              o_hz
);

   logic w_rd_nonzero;
   logic w_src_match;

   // x0 is hard-wired zero, so a load targeting it never creates a dependency
   assign w_rd_nonzero = (i_ex_rd != '0);
   assign w_src_match  = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);
   assign o_hz         = i_ex_valid & i_ex_mem_read & w_rd_nonzero & i_id_valid & w_src_match;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall, flush bubbles and a sticky EBREAK halt.
module id_ex_stage_reg
   import id_ex_stage_reg_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_branch,
   input  logic              id_mem_read,
   input  logic              id_mem_to_reg,
   input  logic [1:0]        id_alu_op,
   input  logic              id_mem_write,
   input  logic              id_alu_src,
   input  logic              id_reg_write,
   input  logic              id_pc_write,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [2:0]        id_funct3,
   input  logic              id_inst30,
   input  logic              flush,
   output logic              ex_valid,
   output logic              ex_branch,
   output logic              ex_mem_read,
   output logic              ex_mem_to_reg,
   output logic [1:0]        ex_alu_op,
   output logic              ex_mem_write,
   output logic              ex_alu_src,
   output logic              ex_reg_write,
   output logic              ex_pc_write,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [2:0]        ex_funct3,
   output logic              ex_inst30,
   output logic              stall,
   output logic              halted
);

   state_t            r_state;
   logic              r_halted;
   logic              r_ex_valid;
   ctrl_t             r_ex_ctrl;
   logic [XLEN-1:0]   r_ex_pc;
   logic [XLEN-1:0]   r_ex_rs1_data;
   logic [XLEN-1:0]   r_ex_rs2_data;
   logic [XLEN-1:0]   r_ex_imm;
   logic [REG_AW-1:0] r_ex_rs1;
   logic [REG_AW-1:0] r_ex_rs2;
   logic [REG_AW-1:0] r_ex_rd;
   logic [2:0]        r_ex_funct3;
   logic              r_ex_inst30;

   ctrl_t             w_id_ctrl;
   logic              w_hz;
   logic              w_stall;

   assign w_id_ctrl = '{branch:     id_branch,
                        mem_read:   id_mem_read,
                        mem_to_reg: id_mem_to_reg,
                        alu_op:     id_alu_op,
                        mem_write:  id_mem_write,
                        alu_src:    id_alu_src,
                        reg_write:  id_reg_write,
                        pc_write:   id_pc_write};

   hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
      .i_ex_valid    (r_ex_valid),
      .i_ex_mem_read (r_ex_ctrl.mem_read),
      .i_ex_rd       (r_ex_rd),
      .i_id_valid    (id_valid),
      .i_id_rs1      (id_rs1),
      .i_id_rs2      (id_rs2),
      .o_hz          (w_hz)
   );

   // A taken branch squashes the dependent instruction, so holding IF/ID would be wrong
   assign w_stall = w_hz & ~flush & ~r_halted;

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_halted      <= 1'b0;
         r_ex_valid    <= 1'b0;
         r_ex_ctrl     <= CTRL_NOP;
         r_ex_pc       <= '0;
         r_ex_rs1_data <= '0;
         r_ex_rs2_data <= '0;
         r_ex_imm      <= '0;
         r_ex_rs1      <= '0;
         r_ex_rs2      <= '0;
         r_ex_rd       <= '0;
         r_ex_funct3   <= '0;
         r_ex_inst30   <= 1'b0;
      end else begin
         // Default is a bubble; only a clean capture in RUN overrides it
         r_ex_valid <= 1'b0;
         r_ex_ctrl  <= CTRL_NOP;
         if (r_state == ST_RUN) begin
            r_ex_pc       <= id_pc;
            r_ex_rs1_data <= id_rs1_data;
            r_ex_rs2_data <= id_rs2_data;
            r_ex_imm      <= id_imm;
            r_ex_rs1      <= id_rs1;
            r_ex_rs2      <= id_rs2;
            r_ex_rd       <= id_rd;
            r_ex_funct3   <= id_funct3;
            r_ex_inst30   <= id_inst30;
            if (flush || w_stall) begin
               r_ex_valid <= 1'b0;
            end else if (id_valid && !id_pc_write) begin
               r_ex_valid <= 1'b1;
               r_state    <= ST_HALT;
               r_halted   <= 1'b1;
            end else if (id_valid) begin
               r_ex_valid <= 1'b1;
               r_ex_ctrl  <= w_id_ctrl;
            end
         end
      end
   end

   assign ex_valid      = r_ex_valid;
   assign ex_branch     = r_ex_ctrl.branch;
   assign ex_mem_read   = r_ex_ctrl.mem_read;
   assign ex_mem_to_reg = r_ex_ctrl.mem_to_reg;
   assign ex_alu_op     = r_ex_ctrl.alu_op;
   assign ex_mem_write  = r_ex_ctrl.mem_write;
   assign ex_alu_src    = r_ex_ctrl.alu_src;
   assign ex_reg_write  = r_ex_ctrl.reg_write;
   assign ex_pc_write   = r_ex_ctrl.pc_write;
   assign ex_pc         = r_ex_pc;
   assign ex_rs1_data   = r_ex_rs1_data;
   assign ex_rs2_data   = r_ex_rs2_data;
   assign ex_imm        = r_ex_imm;
   assign ex_rs1        = r_ex_rs1;
   assign ex_rs2        = r_ex_rs2;
   assign ex_rd         = r_ex_rd;
   assign ex_funct3     = r_ex_funct3;
   assign ex_inst30     = r_ex_inst30;
   assign stall         = w_stall;
   assign halted        = r_halted;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed vector bench for id_ex_stage_reg: table of single-edge vectors plus hand-written
// rst-mid-stall and halt sequences.
module tb_id_ex_stage_reg;

   // Control bundle order: {branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write, pc_write}
   localparam logic [8:0] C_ADDI = 9'h037;
   localparam logic [8:0] C_LW   = 9'h0C7;
   localparam logic [8:0] C_ADD  = 9'h023;
   localparam logic [8:0] C_SW   = 9'h00D;
   localparam logic [8:0] C_BEQ  = 9'h111;
   localparam logic [8:0] C_EBRK = 9'h000;

   logic        clk, rst, id_valid, flush;
   logic        id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_pc_write;
   logic [1:0]  id_alu_op;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [2:0]  id_funct3;
   logic        id_inst30;
   logic        ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_pc_write;
   logic [1:0]  ex_alu_op;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_funct3;
   logic        ex_inst30, stall, halted;

   int n_checks = 0;
   int n_err    = 0;

   id_ex_stage_reg #(.XLEN(32), .REG_AW(5)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_branch(id_branch), .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
      .id_alu_op(id_alu_op), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
      .id_reg_write(id_reg_write), .id_pc_write(id_pc_write),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .id_inst30(id_inst30),
      .flush(flush),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_alu_op(ex_alu_op), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
      .ex_reg_write(ex_reg_write), .ex_pc_write(ex_pc_write),
      .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_inst30(ex_inst30),
      .stall(stall), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst, vld, flush;
      logic [8:0]  ctrl;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic        chk_stall, exp_stall, exp_valid;
      logic [8:0]  exp_ctrl;
   } vec_t;

   vec_t tbl[17];

   function automatic vec_t mk(input logic r, v, f, input logic [8:0] c, input logic [4:0] s1, s2, d,
                               input logic [31:0] im, input logic cs, es, ev, input logic [8:0] ec);
      vec_t t;
      t.rst = r; t.vld = v; t.flush = f; t.ctrl = c; t.rs1 = s1; t.rs2 = s2; t.rd = d; t.imm = im;
      t.chk_stall = cs; t.exp_stall = es; t.exp_valid = ev; t.exp_ctrl = ec;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, v, f, input logic [8:0] c, input logic [4:0] s1, s2, d,
                        input logic [31:0] im, input logic [31:0] pc);
      rst = r; id_valid = v; flush = f;
      {id_branch, id_mem_read, id_mem_to_reg, id_alu_op, id_mem_write, id_alu_src, id_reg_write, id_pc_write} = c;
      id_rs1 = s1; id_rs2 = s2; id_rd = d; id_imm = im; id_pc = pc;
      id_rs1_data = im ^ 32'h1111_1111;
      id_rs2_data = im ^ 32'h2222_2222;
      id_funct3   = d[2:0] ^ 3'b101;
      id_inst30   = d[0];
   endtask

   // Compares the EX side after an edge; data fields only matter when a real instruction was captured
   task automatic check_ex(input string tag, input logic ev, input logic [8:0] ec, input logic eh,
                           input logic [4:0] s1, s2, d, input logic [31:0] im, pc);
      logic [8:0] act_ctrl;
      act_ctrl = {ex_branch, ex_mem_read, ex_mem_to_reg, ex_alu_op, ex_mem_write, ex_alu_src, ex_reg_write, ex_pc_write};
      check({tag, "_valid"}, {31'd0, ex_valid}, {31'd0, ev});
      check({tag, "_ctrl"}, {23'd0, act_ctrl}, {23'd0, ec});
      check({tag, "_halted"}, {31'd0, halted}, {31'd0, eh});
      if (ev) begin
         check({tag, "_regs"}, {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, s1, s2, d});
         check({tag, "_imm"}, ex_imm, im);
         check({tag, "_pc"}, ex_pc, pc);
         check({tag, "_rs1_data"}, ex_rs1_data, im ^ 32'h1111_1111);
         check({tag, "_rs2_data"}, ex_rs2_data, im ^ 32'h2222_2222);
         check({tag, "_f3_i30"}, {28'd0, ex_funct3, ex_inst30}, {28'd0, d[2:0] ^ 3'b101, d[0]});
      end
   endtask

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] pc;
      //            rst  v    f    ctrl    rs1 rs2 rd imm    chk  stall valid exp_ctrl
      tbl[0]  = mk(1'b1,1'b1,1'b0,C_ADDI, 5'd0,5'd0,5'd3, 32'd7, 1'b0,1'b0,1'b0,9'h000);
      tbl[1]  = mk(1'b1,1'b1,1'b0,C_ADDI, 5'd0,5'd0,5'd3, 32'd7, 1'b1,1'b0,1'b0,9'h000);
      tbl[2]  = mk(1'b0,1'b1,1'b0,C_ADDI, 5'd0,5'd0,5'd1, 32'd5, 1'b1,1'b0,1'b1,C_ADDI);
      tbl[3]  = mk(1'b0,1'b1,1'b0,C_LW,   5'd2,5'd0,5'd5, 32'd0, 1'b1,1'b0,1'b1,C_LW);
      tbl[4]  = mk(1'b0,1'b1,1'b0,C_ADD,  5'd5,5'd1,5'd6, 32'd0, 1'b1,1'b1,1'b0,9'h000);
      tbl[5]  = mk(1'b0,1'b1,1'b0,C_ADD,  5'd5,5'd1,5'd6, 32'd0, 1'b1,1'b0,1'b1,C_ADD);
      tbl[6]  = mk(1'b0,1'b1,1'b0,C_LW,   5'd2,5'd0,5'd0, 32'd0, 1'b1,1'b0,1'b1,C_LW);
      tbl[7]  = mk(1'b0,1'b1,1'b0,C_ADD,  5'd0,5'd1,5'd6, 32'd0, 1'b1,1'b0,1'b1,C_ADD);
      tbl[8]  = mk(1'b0,1'b1,1'b0,C_LW,   5'd2,5'd0,5'd5, 32'd4, 1'b1,1'b0,1'b1,C_LW);
      tbl[9]  = mk(1'b0,1'b1,1'b1,C_ADD,  5'd5,5'd1,5'd6, 32'd0, 1'b1,1'b0,1'b0,9'h000);
      tbl[10] = mk(1'b0,1'b1,1'b0,C_ADD,  5'd1,5'd5,5'd7, 32'd0, 1'b1,1'b0,1'b1,C_ADD);
      tbl[11] = mk(1'b0,1'b1,1'b0,C_LW,   5'd2,5'd0,5'd5, 32'd12,1'b1,1'b0,1'b1,C_LW);
      tbl[12] = mk(1'b0,1'b1,1'b0,C_SW,   5'd2,5'd5,5'd0, 32'd8, 1'b1,1'b1,1'b0,9'h000);
      tbl[13] = mk(1'b0,1'b1,1'b0,C_SW,   5'd2,5'd5,5'd0, 32'd8, 1'b1,1'b0,1'b1,C_SW);
      tbl[14] = mk(1'b0,1'b1,1'b0,C_LW,   5'd2,5'd0,5'd5, 32'd16,1'b1,1'b0,1'b1,C_LW);
      tbl[15] = mk(1'b0,1'b0,1'b0,C_ADD,  5'd5,5'd1,5'd6, 32'd0, 1'b1,1'b0,1'b0,9'h000);
      tbl[16] = mk(1'b0,1'b1,1'b0,C_BEQ,  5'd1,5'd2,5'd0, 32'd16,1'b1,1'b0,1'b1,C_BEQ);

      for (int i = 0; i < 17; i++) begin
         pc = 32'h1000 + 32'(i) * 4;
         drive(tbl[i].rst, tbl[i].vld, tbl[i].flush, tbl[i].ctrl, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm, pc);
         #1;
         if (tbl[i].chk_stall)
            check($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].exp_stall});
         edge_settle();
         check_ex($sformatf("v%0d", i), tbl[i].exp_valid, tbl[i].exp_ctrl, 1'b0,
                  tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm, pc);
         if (tbl[i].rst)
            check($sformatf("v%0d_rst_data", i),
                  ex_pc | ex_imm | ex_rs1_data | ex_rs2_data | {14'd0, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_inst30},
                  32'd0);
      end

      // rst arriving mid-stall: bubble, then the held ADD is captured cleanly
      drive(1'b0, 1'b1, 1'b0, C_LW, 5'd2, 5'd0, 5'd5, 32'd0, 32'h2000);
      edge_settle();
      drive(1'b0, 1'b1, 1'b0, C_ADD, 5'd5, 5'd1, 5'd6, 32'd0, 32'h2004);
      #1 check("rst_mid_stall_pre", {31'd0, stall}, 32'd1);
      drive(1'b1, 1'b1, 1'b0, C_ADD, 5'd5, 5'd1, 5'd6, 32'd0, 32'h2004);
      edge_settle();
      check_ex("rst_mid_stall", 1'b0, 9'h000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      drive(1'b0, 1'b1, 1'b0, C_ADD, 5'd5, 5'd1, 5'd6, 32'd0, 32'h2004);
      #1 check("after_rst_stall", {31'd0, stall}, 32'd0);
      edge_settle();
      check_ex("after_rst_cap", 1'b1, C_ADD, 1'b0, 5'd5, 5'd1, 5'd6, 32'd0, 32'h2004);

      // Stall outranks halt-detect: EBREAK reading the load target is held, not halted
      drive(1'b0, 1'b1, 1'b0, C_LW, 5'd2, 5'd0, 5'd5, 32'd0, 32'h3000);
      edge_settle();
      drive(1'b0, 1'b1, 1'b0, C_EBRK, 5'd5, 5'd0, 5'd0, 32'd1, 32'h3004);
      #1 check("ebrk_stall", {31'd0, stall}, 32'd1);
      edge_settle();
      check_ex("ebrk_stalled", 1'b0, 9'h000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);

      // Flushed or invalid EBREAK must not halt
      drive(1'b0, 1'b1, 1'b1, C_EBRK, 5'd0, 5'd0, 5'd0, 32'd1, 32'h3008);
      edge_settle();
      check_ex("ebrk_flushed", 1'b0, 9'h000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      drive(1'b0, 1'b0, 1'b0, C_EBRK, 5'd0, 5'd0, 5'd0, 32'd1, 32'h300C);
      edge_settle();
      check_ex("ebrk_invalid", 1'b0, 9'h000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);

      // Real EBREAK: captured as a valid NOP, halt becomes sticky
      drive(1'b0, 1'b1, 1'b0, C_EBRK, 5'd0, 5'd0, 5'd0, 32'd1, 32'h3010);
      edge_settle();
      check_ex("ebrk_halt", 1'b1, 9'h000, 1'b1, 5'd0, 5'd0, 5'd0, 32'd1, 32'h3010);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 1'b0, (k == 1) ? C_LW : C_ADDI, 5'd0, 5'd0, 5'd4, 32'd9, 32'h3014);
         #1 check($sformatf("halt%0d_stall", k), {31'd0, stall}, 32'd0);
         edge_settle();
         check_ex($sformatf("halt%0d", k), 1'b0, 9'h000, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      end
      drive(1'b1, 1'b1, 1'b0, C_ADDI, 5'd0, 5'd0, 5'd4, 32'd9, 32'h3014);
      edge_settle();
      check_ex("halt_rst", 1'b0, 9'h000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      drive(1'b0, 1'b1, 1'b0, C_ADDI, 5'd0, 5'd0, 5'd4, 32'd9, 32'h3018);
      edge_settle();
      check_ex("post_halt_cap", 1'b1, C_ADDI, 1'b0, 5'd0, 5'd0, 5'd4, 32'd9, 32'h3018);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

endmodule
